// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the multi-channel debouncer: mode selectors,
//   lockout-mode state encoding and the parameter range check used at
//   elaboration by the top level.
package debounce_pkg;

    localparam int DEB_MODE_STABLE  = 0;  // level follows input after a stable interval
    localparam int DEB_MODE_LOCKOUT = 1;  // accept first edge, then ignore input for an interval

    typedef enum logic {
        LK_IDLE = 1'b0,
        LK_HOLD = 1'b1
    } lockState_t;

    // Returns 1 when every parameter lies in its legal range.
    function automatic bit debParamsOk(
        input int     channels,
        input int     cntWidth,
        input longint debounceCycles,
        input int     syncStages,
        input int     mode
    );
        longint maxCycles;
        if (cntWidth < 1 || cntWidth > 62) return 1'b0;
        maxCycles = (longint'(1) << cntWidth) - 1;
        return (channels >= 1) && (syncStages >= 2) &&
               (debounceCycles >= 1) && (debounceCycles <= maxCycles) &&
               (mode == DEB_MODE_STABLE || mode == DEB_MODE_LOCKOUT);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One input channel: SYNC_STAGES-flop synchroniser, debounce counter,
//   stable-wait or lockout decision logic and registered edge pulses.
// Ports:
//   iCLK          clock, rising edge
//   iRST          asynchronous active-high reset
//   iIn           raw asynchronous input
//   oLEVEL        debounced level (resets to RESET_LEVEL)
//   oRISING_EDGE  one-cycle pulse when oLEVEL goes 0->1
//   oFALLING_EDGE one-cycle pulse when oLEVEL goes 1->0
//   oBUSY         debounce interval in progress
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int     CNT_WIDTH       = 16,
    parameter longint DEBOUNCE_CYCLES = 64'hF00F,
    parameter int     SYNC_STAGES     = 2,
    parameter int     MODE            = DEB_MODE_STABLE,
    parameter logic   RESET_LEVEL     = 1'b0
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iIn,
    output logic oLEVEL,
    output logic oRISING_EDGE,
    output logic oFALLING_EDGE,
    output logic oBUSY
);

    localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] syncPipe;
    logic                   s;
    logic [CNT_WIDTH-1:0]   cnt, cntNext;
    lockState_t             state, stateNext;
    logic                   levelNext, riseNext, fallNext;

    assign s = syncPipe[SYNC_STAGES-1];

    // Synchroniser and level both reset to RESET_LEVEL so that reset
    // release with a matching input never produces an event.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            syncPipe      <= {SYNC_STAGES{RESET_LEVEL}};
            oLEVEL        <= RESET_LEVEL;
            oRISING_EDGE  <= 1'b0;
            oFALLING_EDGE <= 1'b0;
            cnt           <= '0;
            state         <= LK_IDLE;
        end else begin
            syncPipe      <= {syncPipe[SYNC_STAGES-2:0], iIn};
            oLEVEL        <= levelNext;
            oRISING_EDGE  <= riseNext;
            oFALLING_EDGE <= fallNext;
            cnt           <= cntNext;
            state         <= stateNext;
        end
    end

    // Accepting an edge always moves level to s; since s != level at that
    // point, s itself tells rising from falling.
    always_comb begin
        levelNext = oLEVEL;
        riseNext  = 1'b0;
        fallNext  = 1'b0;
        cntNext   = cnt;
        stateNext = state;
        if (MODE == DEB_MODE_STABLE) begin
            stateNext = LK_IDLE;
            if (s == oLEVEL) begin
                cntNext = '0;
            end else if (cnt == TERM) begin
                // terminal compare before increment: counter never wraps
                levelNext = s;
                riseNext  = s;
                fallNext  = ~s;
                cntNext   = '0;
            end else begin
                cntNext = cnt + CNT_WIDTH'(1);
            end
        end else begin
            case (state)
                LK_IDLE: begin
                    cntNext = '0;
                    if (s != oLEVEL) begin
                        levelNext = s;
                        riseNext  = s;
                        fallNext  = ~s;
                        stateNext = LK_HOLD;
                    end
                end
                LK_HOLD: begin
                    // input ignored until the hold interval expires
                    if (cnt == TERM) begin
                        cntNext   = '0;
                        stateNext = LK_IDLE;
                    end else begin
                        cntNext = cnt + CNT_WIDTH'(1);
                    end
                end
                default: stateNext = LK_IDLE;
            endcase
        end
    end

    assign oBUSY = (MODE == DEB_MODE_STABLE) ? (cnt != '0) : (state == LK_HOLD);

endmodule

// File: rtl/multi_channel_debouncer.sv
// multi_channel_debouncer
//   CHANNELS independent debounce channels plus a summary event flag.
// Ports:
//   iCLK          clock, rising edge
//   iRST          asynchronous active-high reset
//   iIn           raw asynchronous inputs, one per channel
//   oLEVEL        debounced levels
//   oRISING_EDGE  per-channel one-cycle rising pulses
//   oFALLING_EDGE per-channel one-cycle falling pulses
//   oBUSY         per-channel debounce interval in progress
//   oANY_EVENT    OR of all rising and falling pulses (no added latency)
module multi_channel_debouncer
    import debounce_pkg::*;
#(
    parameter int     CHANNELS        = 4,
    parameter int     CNT_WIDTH       = 16,
    parameter longint DEBOUNCE_CYCLES = 64'hF00F,
    parameter int     SYNC_STAGES     = 2,
    parameter int     MODE            = DEB_MODE_STABLE,
    parameter logic   RESET_LEVEL     = 1'b0
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic [CHANNELS-1:0] iIn,
    output logic [CHANNELS-1:0] oLEVEL,
    output logic [CHANNELS-1:0] oRISING_EDGE,
    output logic [CHANNELS-1:0] oFALLING_EDGE,
    output logic [CHANNELS-1:0] oBUSY,
    output logic                oANY_EVENT
);

    generate
        if (!debParamsOk(CHANNELS, CNT_WIDTH, DEBOUNCE_CYCLES, SYNC_STAGES, MODE)) begin : gParamErr
            $error("multi_channel_debouncer: parameter out of range");
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : gCh
            debounce_channel #(
                .CNT_WIDTH      (CNT_WIDTH),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_STAGES    (SYNC_STAGES),
                .MODE           (MODE),
                .RESET_LEVEL    (RESET_LEVEL)
            ) uCh (
                .iCLK         (iCLK),
                .iRST         (iRST),
                .iIn          (iIn[i]),
                .oLEVEL       (oLEVEL[i]),
                .oRISING_EDGE (oRISING_EDGE[i]),
                .oFALLING_EDGE(oFALLING_EDGE[i]),
                .oBUSY        (oBUSY[i])
            );
        end
    endgenerate

    assign oANY_EVENT = |(oRISING_EDGE | oFALLING_EDGE);

endmodule

// File: doc/multi_channel_debouncer.md
# multi_channel_debouncer

Parametrised N-channel input conditioner for push-buttons, jumpers and slow control strobes feeding the si570 controller and board-management logic. Each channel synchronises an asynchronous input, debounces it in one of two selectable modes, and presents a clean level plus single-cycle rising and falling event pulses. A summary event flag lets a single consumer poll all channels.

## Interface
- CHANNELS, 4: number of independent input channels, ≥1.
- CNT_WIDTH, 16: debounce counter width.
- DEBOUNCE_CYCLES, 16'hF00F: debounce interval in clock cycles, 1 ≤ value ≤ 2^CNT_WIDTH−1. Elaboration error otherwise.
- SYNC_STAGES, 2: synchroniser depth, ≥2.
- MODE, 0: 0 = stable-wait, 1 = lockout. Applies to all channels.
- RESET_LEVEL, 1'b0: reset value of the synchroniser flops and oLEVEL on every channel.

Ports:
- iCLK  in  1  sole clock, rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iIn  in  CHANNELS  raw asynchronous inputs.
- oLEVEL  out  CHANNELS  debounced level. Reset value: RESET_LEVEL.
- oRISING_EDGE  out  CHANNELS  one-cycle pulse when oLEVEL goes 0→1. Reset value: 0.
- oFALLING_EDGE  out  CHANNELS  one-cycle pulse when oLEVEL goes 1→0. Reset value: 0.
- oBUSY  out  CHANNELS  debounce interval in progress. Reset value: 0.
- oANY_EVENT  out  1  OR of all rising and falling pulses. Reset value: 0.

## Operation
- Per channel: SYNC_STAGES-flop synchroniser produces s. All flops reset to RESET_LEVEL, so reset release never produces an event.
- Stable-wait mode (MODE=0), counter cnt per channel:
  - s == oLEVEL: cnt ← 0.
  - s ≠ oLEVEL and cnt == DEBOUNCE_CYCLES−1: oLEVEL ← s, matching edge pulse ← 1, cnt ← 0.
  - s ≠ oLEVEL otherwise: cnt ← cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles is discarded, and the count restarts from 0.
  - oBUSY = (cnt ≠ 0).
- Lockout mode (MODE=1), states IDLE and HOLD:
  - IDLE with s ≠ oLEVEL: oLEVEL ← s, edge pulse, cnt ← 0, go to HOLD.
  - HOLD: s is ignored and cnt increments. At cnt == DEBOUNCE_CYCLES−1, cnt ← 0 and the channel returns to IDLE.
  - If s still differs from oLEVEL when the channel is back in IDLE, the next edge is accepted on the following clock.
  - oBUSY = (state == HOLD).
- Pulses are registered and exactly one cycle wide. Rising and falling never assert together on one channel.
- Channels are fully independent. Simultaneous events on several channels each pulse in the same cycle.
- oANY_EVENT is a combinational OR of registered pulses and carries no added latency.
- Counters never wrap: the terminal compare precedes the increment.

## Timing
- Count edges from the first iCLK edge that samples iIn at its new value, calling that edge 1.
- Stable-wait: oLEVEL and the pulse update at edge SYNC_STAGES + DEBOUNCE_CYCLES.
- Lockout: oLEVEL and the pulse update at edge SYNC_STAGES + 1. The channel then stays in HOLD for DEBOUNCE_CYCLES cycles.
- DEBOUNCE_CYCLES = 1: stable-wait latency is SYNC_STAGES + 1. Lockout HOLD lasts one cycle.
- iRST asserted mid-count: all state returns to reset values asynchronously, and no pulse is emitted on release.

## Structure
- Shared package `debounce_pkg`:
  - constants DEB_MODE_STABLE = 0 and DEB_MODE_LOCKOUT = 1;
  - lockout state encoding;
  - elaboration-check helper for the parameter ranges.
- One sub-module, `debounce_channel`, containing the synchroniser, counter, mode logic and pulse registers. It is instantiated CHANNELS times in a generate loop.
- Top level: generate loop plus the oANY_EVENT reduction.

## Test plan
All scenarios use CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless stated.
- Reset release with iIn=2'b00, then hold for 20 cycles: oLEVEL=00 and no pulses throughout. Repeat with RESET_LEVEL=1 and iIn=11: same, no pulses.
- MODE=0, iIn[0] 0→1 held: oRISING_EDGE[0] pulses for exactly one cycle at edge 6, oLEVEL[0]=1 from edge 6, oBUSY[0] high for 3 cycles. Channel 1 shows no activity.
- MODE=0, iIn[0] high for 3 cycles then low: no pulse, oLEVEL[0] stays 0, cnt returns to 0.
- MODE=1, iIn[0] toggles 0→1→0→1 every cycle from edge 1:
  - rising pulse at edge 3, then oBUSY[0] for 4 cycles;
  - changes during HOLD are ignored;
  - a final steady 0 then yields a falling pulse on the first cycle after HOLD ends.
- MODE=0, both channels rise on the same edge: both rising pulses and oANY_EVENT assert together at edge 6.
- iRST asserted while oBUSY[0]=1 at cnt=2: all outputs reset immediately, and no pulse appears after release with iIn unchanged at 0.
